serial_tx_fifo: RTL and testbench

- UART transmitter that drains the tx_data / new_tx_data / tx_busy byte interface driven by message_printer-style producers.
- Serialises bytes onto the tx pin as 8N1 frames, with optional parity and optional second stop bit.
- A small FIFO decouples producer bursts from line rate.
- Sits between the message/command logic and the board TX pin. It is the transmit-side counterpart of the existing receive path.

---
 rtl/serial_tx_fifo.sv | 169 ++++++++++++++++
 tb/tb_serial_tx_fifo.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_fifo.sv
// UART transmitter with a small byte FIFO in front of it.
// Frames are 8 data bits LSB first, with optional parity and one or two stop bits.
module serial_tx_fifo #(
    parameter int CLK_PER_BIT = 50,
    parameter int FIFO_DEPTH  = 4,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       new_data,
    output logic       busy,
    input  logic       block,
    output logic       tx,
    output logic       overflow,
    output logic       idle
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int KW = $clog2(CLK_PER_BIT);
    localparam logic [KW-1:0] K_LAST    = KW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          tx_q, tx_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];

    logic wr;
    logic pop;
    logic bit_end;
    logic can_start;

    assign busy      = (count_q == FULL);
    assign idle      = (count_q == '0) && (state_q == S_IDLE);
    assign tx        = tx_q;
    assign overflow  = ovf_q;
    assign wr        = new_data && !busy;
    assign bit_end   = (cnt_q == K_LAST);
    assign can_start = (count_q != '0) && !block;

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + KW'(1);
        bit_d   = bit_q;
        sh_d    = sh_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        mem_d   = mem_q;
        ovf_d   = new_data && busy;
        pop     = 1'b0;
        tx_d    = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                pop   = can_start;
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                        bit_d   = '0;
                    end
                end
            end
            S_PAR: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        // back-to-back frames skip IDLE entirely
                        if (can_start) pop = 1'b1;
                        else state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            state_d = S_START;
            cnt_d   = '0;
            bit_d   = '0;
            sh_d    = mem_q[rptr_q];
            rptr_d  = rptr_q + AW'(1);
        end

        if (wr) begin
            mem_d[wptr_q] = data;
            wptr_d        = wptr_q + AW'(1);
        end

        unique case ({wr, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // tx is registered, so it follows the state being entered
        unique case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = sh_d[bit_d];
            S_PAR:   tx_d = (PARITY == 1) ? ~^sh_d : ^sh_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Bench for serial_tx_fifo: three instances (no, even, odd parity).
// A serial monitor per instance decodes frames and checks them against queued bytes.
module tb_serial_tx_fifo;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din [3];
    logic       nd  [3];
    logic       blk [3];
    logic       tx  [3];
    logic       busy[3];
    logic       ovf [3];
    logic       idl [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frames [3];
    int ovf_cnt[3];
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    logic [7:0] exp_q2[$];
    int starts0[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) if (ovf[i] === 1'b1) ovf_cnt[i]++;
    end

    serial_tx_fifo #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .data(din[0]), .new_data(nd[0]), .busy(busy[0]),
        .block(blk[0]), .tx(tx[0]), .overflow(ovf[0]), .idle(idl[0])
    );
    serial_tx_fifo #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(1)) u_b (
        .clk(clk), .rst_n(rst_n), .data(din[1]), .new_data(nd[1]), .busy(busy[1]),
        .block(blk[1]), .tx(tx[1]), .overflow(ovf[1]), .idle(idl[1])
    );
    serial_tx_fifo #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(1)) u_c (
        .clk(clk), .rst_n(rst_n), .data(din[2]), .new_data(nd[2]), .busy(busy[2]),
        .block(blk[2]), .tx(tx[2]), .overflow(ovf[2]), .idle(idl[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic int par_of(input int idx);
        case (idx)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_size(input int idx);
        case (idx)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic logic [7:0] exp_pop(input int idx);
        case (idx)
            0:       return exp_q0.pop_front();
            1:       return exp_q1.pop_front();
            default: return exp_q2.pop_front();
        endcase
    endfunction

    task automatic exp_push(input int idx, input logic [7:0] b);
        case (idx)
            0:       exp_q0.push_back(b);
            1:       exp_q1.push_back(b);
            default: exp_q2.push_back(b);
        endcase
    endtask

    task automatic samp(input int idx, output logic v, output logic r);
        @(negedge clk);
        v = tx[idx];
        r = rst_n;
    endtask

    task automatic mon(input int idx);
        logic [7:0] b;
        logic [7:0] e;
        logic v, r, p, ok, ab;
        int s;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx[idx] === 1'b0) begin
                s = cyc; ok = 1'b1; ab = 1'b0; b = '0; p = 1'b0;
                for (int j = 1; j < CPB; j++) begin
                    samp(idx, v, r); ab |= ~r;
                    if (v !== 1'b0) ok = 1'b0;
                end
                for (int k = 0; k < 8; k++) begin
                    for (int j = 0; j < CPB; j++) begin
                        samp(idx, v, r); ab |= ~r;
                        if (j == 0) b[k] = v;
                        else if (v !== b[k]) ok = 1'b0;
                    end
                end
                if (par_of(idx) != 0) begin
                    for (int j = 0; j < CPB; j++) begin
                        samp(idx, v, r); ab |= ~r;
                        if (j == 0) p = v;
                        else if (v !== p) ok = 1'b0;
                    end
                end
                for (int j = 0; j < CPB; j++) begin
                    samp(idx, v, r); ab |= ~r;
                    if (v !== 1'b1) ok = 1'b0;
                end
                if (!ab) begin
                    frames[idx]++;
                    if (idx == 0) starts0.push_back(s);
                    chk($sformatf("frame_shape%0d", idx), 32'(ok), 32'd1);
                    if (exp_size(idx) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame%0d: got %0h expected none", idx, b);
                    end else begin
                        e = exp_pop(idx);
                        chk($sformatf("frame_byte%0d", idx), 32'(b), 32'(e));
                        if (par_of(idx) == 2) chk("parity_even", 32'(p), 32'(^e));
                        if (par_of(idx) == 1) chk("parity_odd", 32'(p), 32'(~^e));
                    end
                end
            end
        end
    endtask

    initial begin
        fork
            mon(0);
            mon(1);
            mon(2);
        join_none
    end

    task automatic wr(input int idx, input logic [7:0] b);
        din[idx] = b;
        nd[idx]  = 1'b1;
        if (busy[idx] !== 1'b1) exp_push(idx, b);
        @(posedge clk);
        #1;
        nd[idx] = 1'b0;
    endtask

    task automatic wait_idle(input int idx, output int n);
        n = 0;
        while (idl[idx] !== 1'b1 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int n, f, o, t;
        for (int i = 0; i < 3; i++) begin
            din[i] = '0; nd[i] = 1'b0; blk[i] = 1'b0;
            frames[i] = 0; ovf_cnt[i] = 0;
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_tx%0d", i), 32'(tx[i]), 32'd1);
            chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
            chk($sformatf("rst_ovf%0d", i), 32'(ovf[i]), 32'd0);
            chk($sformatf("rst_idle%0d", i), 32'(idl[i]), 32'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single byte, latency and frame length
        wr(0, 8'h55);
        chk("lat_e0_tx", 32'(tx[0]), 32'd1);
        chk("lat_e0_idle", 32'(idl[0]), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_e1_tx", 32'(tx[0]), 32'd0);
        wait_idle(0, n);
        chk("frame_len_none", 32'(n), 32'd40);

        // parity variants
        wr(1, 8'h07);
        @(posedge clk);
        #1;
        wait_idle(1, n);
        chk("frame_len_even", 32'(n), 32'd44);
        wr(2, 8'h07);
        @(posedge clk);
        #1;
        wait_idle(2, n);
        chk("frame_len_odd", 32'(n), 32'd44);

        // burst into full FIFO
        starts0.delete();
        o = ovf_cnt[0];
        for (int i = 1; i <= 5; i++) wr(0, 8'(i));
        chk("busy_before_6th", 32'(busy[0]), 32'd1);
        wr(0, 8'h06);
        repeat (3) @(posedge clk);
        #1;
        chk("overflow_pulses", 32'(ovf_cnt[0] - o), 32'd1);
        wait_idle(0, n);
        chk("burst_idle", 32'(idl[0]), 32'd1);
        chk("burst_frames", 32'(starts0.size()), 32'd5);
        for (int k = 1; k < starts0.size(); k++)
            chk($sformatf("burst_gap%0d", k), 32'(starts0[k] - starts0[k-1]), 32'd40);

        // block holds a queued byte
        blk[0] = 1'b1;
        wr(0, 8'hA5);
        t = 1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (tx[0] !== 1'b1) t = 0;
        end
        chk("blocked_tx_high", 32'(t), 32'd1);
        chk("blocked_idle", 32'(idl[0]), 32'd0);
        blk[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("unblock_tx_fall", 32'(tx[0]), 32'd0);
        wait_idle(0, n);

        // block asserted mid-frame
        f = frames[0];
        wr(0, 8'h3C);
        @(posedge clk);
        #1;
        wr(0, 8'h3D);
        repeat (8) @(posedge clk);
        #1;
        blk[0] = 1'b1;
        repeat (45) @(posedge clk);
        #1;
        chk("midblock_frames", 32'(frames[0] - f), 32'd1);
        chk("midblock_held", 32'(exp_q0.size()), 32'd1);
        chk("midblock_tx", 32'(tx[0]), 32'd1);
        chk("midblock_idle", 32'(idl[0]), 32'd0);
        blk[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("midblock_release_tx", 32'(tx[0]), 32'd0);
        wait_idle(0, n);
        chk("midblock_drained", 32'(exp_q0.size()), 32'd0);

        // reset during data bit 3 with two bytes queued
        f = frames[0];
        wr(0, 8'h11);
        wr(0, 8'h22);
        wr(0, 8'h33);
        repeat (16) @(posedge clk);
        #2;
        chk("pre_reset_tx", 32'(tx[0]), 32'd0);
        chk("pre_reset_busy", 32'(busy[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx", 32'(tx[0]), 32'd1);
        chk("async_rst_busy", 32'(busy[0]), 32'd0);
        chk("async_rst_idle", 32'(idl[0]), 32'd1);
        exp_q0.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        t = 1;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (tx[0] !== 1'b1) t = 0;
        end
        chk("post_rst_tx_high", 32'(t), 32'd1);
        chk("post_rst_idle", 32'(idl[0]), 32'd1);
        chk("post_rst_no_frame", 32'(frames[0] - f), 32'd0);

        for (int i = 0; i < 3; i++)
            chk($sformatf("queue_empty%0d", i), 32'(exp_size(i)), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
